// File: rtl/swap_pkg.sv
// Shared defaults and helpers for the swap arbiter block.
package swap_pkg;

  localparam int W_DEF    = 8;
  localparam int NREQ_DEF = 2;

  // Width of a requester index. It is never narrower than one bit.
  function automatic int idw(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/bit_reverse.sv
// Purely combinational mirror of a W-bit word, so that out[i] = in[W-1-i].
module bit_reverse #(
  parameter int W = 8
) (
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  for (genvar gi = 0; gi < W; gi++) begin : g_rev
    assign data_o[gi] = data_i[W-1-gi];
  end

endmodule

// File: rtl/swap_arbiter.sv
// Round-robin arbiter that shares one bit-reversal datapath between NREQ requesters
// and places each result in a single registered output slot.
module swap_arbiter
  import swap_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int W    = W_DEF,
  localparam int IDW  = idw(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_swap,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q,  out_data_d;
  logic [IDW-1:0] out_id_q,    out_id_d;
  logic [IDW-1:0] ptr_q,       ptr_d;

  logic [W-1:0]   word [NREQ];
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic           free;
  logic           accept;
  logic [W-1:0]   raw_word;
  logic [W-1:0]   rev_word;
  logic [W-1:0]   res_word;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
    assign word[gi] = req_data[gi*W +: W];
  end

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin : p_scan
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[IDW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  assign free      = !out_valid_q || out_ready;
  assign accept    = grant_vld && free;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

  assign raw_word = word[grant_idx];

  bit_reverse #(.W(W)) u_rev (
    .data_i (raw_word),
    .data_o (rev_word)
  );

  assign res_word = req_swap[grant_idx] ? rev_word : raw_word;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = res_word;
      out_id_d    = grant_idx;
      ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_swap_arbiter.sv
// Scoreboard bench for swap_arbiter (NREQ=4, W=8): directed scenarios followed by
// randomized traffic checked against a queue-based reference model.
module tb_swap_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_swap;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [1:0]      out_id;
  logic            out_ready;

  swap_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_swap  (req_swap),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  bit   mon_en = 1'b0;

  // Reference model state: slot occupancy and priority pointer.
  bit   model_full = 1'b0;
  int   model_ptr  = 0;
  int   wait_cnt [NREQ];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mirror(input logic [7:0] w);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = w[7-b];
    return r;
  endfunction

  // One clock cycle: drive at posedge+1, check handshake at negedge, update model at posedge.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] s,
                      input logic [31:0] d, input logic ordy, input logic rst);
    int   g;
    bit   free;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] acc;
    exp_t e;
    reset     = rst;
    req_valid = v;
    req_swap  = s;
    req_data  = d;
    out_ready = ordy;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && v[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
    end
    free    = !model_full || ordy;
    exp_rdy = (g >= 0 && free) ? NREQ'(1 << g) : '0;
    @(negedge clk);
    chk("req_ready", req_ready, exp_rdy);
    acc = req_valid & req_ready;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          chk("fair_wait_exceeded", wait_cnt[i] > NREQ - 1, 0);
          wait_cnt[i] = 0;
        end else if (v[i]) begin
          if (acc != '0) wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      model_full = 1'b0;
      model_ptr  = 0;
      sb.delete();
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    end else if (g >= 0 && free) begin
      e.id   = 2'(g);
      e.data = s[g] ? mirror(d[g*8 +: 8]) : d[g*8 +: 8];
      sb.push_back(e);
      model_full = 1'b1;
      model_ptr  = (g + 1) % NREQ;
    end else if (model_full && ordy) begin
      model_full = 1'b0;
    end
    #1;
  endtask

  // Monitor: compares whatever the slot presents against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("out_valid", out_valid, sb.size() != 0);
        if (out_valid === 1'b1 && sb.size() != 0) begin
          chk("out_data", out_data, sb[0].data);
          chk("out_id", out_id, sb[0].id);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  logic [7:0] swp_in  [4] = '{8'h01, 8'h1E, 8'hC3, 8'h1E};
  logic       swp_sel [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] swp_exp [4] = '{8'h80, 8'h78, 8'hC3, 8'h1E};

  initial begin
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    reset = 1'b1; req_valid = '0; req_swap = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset held for three cycles with random requests.
    for (int i = 0; i < 3; i++)
      step(4'($urandom), 4'($urandom), $urandom, 1'($urandom), 1'b1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    step(4'hF, 4'h0, 32'h44332211, 1'b1, 1'b0);
    chk("first_grant_id", out_id, 0);
    chk("first_grant_data", out_data, 8'h11);

    // Single requester, swap and pass-through.
    for (int i = 0; i < 4; i++) begin
      step(4'h1, {3'b000, swp_sel[i]}, {24'h0, swp_in[i]}, 1'b1, 1'b0);
      chk("swap_data", out_data, swp_exp[i]);
      chk("swap_id", out_id, 0);
      chk("swap_valid", out_valid, 1);
    end

    // Round-robin between req0 and req1 from a fresh pointer.
    step(4'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(4'h3, 4'h0, 32'h0000A050 + k, 1'b1, 1'b0);
      chk("rr_id", out_id, k % 2);
      chk("rr_valid", out_valid, 1);
    end
    for (int k = 0; k < 3; k++) begin
      step(4'h2, 4'h0, {16'h0, 8'(8'h30 + k), 8'h00}, 1'b1, 1'b0);
      chk("req1_only_id", out_id, 1);
    end

    // Backpressure: slot holds 8'h80, no grants, then drain+accept together.
    step(4'h1, 4'h1, 32'h00000001, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(4'h3, 4'h0, $urandom, 1'b0, 1'b0);
      chk("bp_ready", req_ready, 4'h0);
      chk("bp_data", out_data, 8'h80);
    end
    step(4'h3, 4'h0, 32'h00005500, 1'b1, 1'b0);
    chk("bp_release_id", out_id, 1);
    chk("bp_release_data", out_data, 8'h55);

    // Reset while the slot is full and stalled.
    step(4'h1, 4'h1, 32'h00000003, 1'b1, 1'b0);
    step(4'h3, 4'h0, $urandom, 1'b0, 1'b1);
    chk("midrst_valid", out_valid, 0);
    step(4'h3, 4'h0, 32'h00002211, 1'b1, 1'b0);
    chk("midrst_grant_id", out_id, 0);
    chk("midrst_grant_data", out_data, 8'h11);

    // Randomized traffic.
    for (int c = 0; c < 10000; c++)
      step(4'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3) != 0, 1'b0);
    repeat (3) step(4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    chk("final_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
